spi_master_out: RTL and testbench
=================================

// Module: spi_master_out
// PURPOSE
//  SPI master transmitter (output only); the driving end of the spi_slave_in link.
//  Serialises a BITS-wide word onto cs/sck/mosi, MSB first, with mosi carrying the
//  INVERTED data bit, because the receiver shifts !mosi on each falling SCK edge.
//  Sits in the host/test side of the design and feeds the PID setpoint/gain receivers.
// PARAMETERS
//  BITS    32  word length in bits; must be >= 2.
//  CLKDIV  4   clk cycles per SCK half-period; must be >= 3 (receiver edge-detect margin).
// PORTS
//  clk      in   1     system clock; all logic on posedge.
//  reset_n  in   1     synchronous reset, active-low.
//  start    in   1     request a transfer of data_in; accepted when ready=1.
//  data_in  in   BITS  word to send; sampled in the accept cycle only.
//  ready    out  1     1 = start will be accepted this cycle.
//  busy     out  1     1 = frame in progress (state != IDLE).
//  done     out  1     one-cycle pulse: frame finished, cs back high.
//  cs       out  1     chip select, active-low.
//  sck      out  1     serial clock, idle low.
//  mosi     out  1     serial data = ~bit, MSB first.
// BEHAVIOUR
//  - Reset (reset_n=0 at a posedge): state=IDLE; cs=1, sck=0, mosi=0, busy=0, done=0,
//    ready=1, shift reg/bit count/divider cleared. Holds also when asserted mid-frame.
//    The receiver sees cs rise and keeps the partial bits.
//  - Registers: shift reg[BITS], bit count [$clog2(BITS)], divider [$clog2(CLKDIV)].
//    Every output is registered.
//  - FSM: IDLE -> LEAD -> (HIGH -> LOW) x BITS -> TAIL -> IDLE.
//    Each of LEAD, HIGH, LOW and TAIL lasts exactly CLKDIV cycles.
//  - IDLE: cs=1, sck=0, mosi=0. start&&ready latches data_in. Next cycle: LEAD, cs=0, busy=1.
//  - LEAD: cs=0, sck=0 (CS-to-SCK setup).
//  - HIGH: on entry sck=1 and mosi=~shreg[BITS-1]. mosi stays stable through HIGH and
//    the following LOW, so it is stable around the falling edge.
//  - LOW: sck=0; the receiver samples on this falling edge. At the end of LOW: if
//    count==BITS-1, go to TAIL; else shift left by 1, count+1, go to HIGH.
//  - TAIL: cs=0, sck=0 (hold after the last falling edge).
//    Next cycle: IDLE, cs=1, busy=0, done=1 for 1 cycle.
//  - cs is low for exactly CLKDIV*(2*BITS+2) cycles. There are exactly BITS rising
//    and BITS falling SCK edges.
//  - Latency: start accepted at edge k -> done high in cycle k+1+CLKDIV*(2*BITS+2).
//  - start while busy (macro off): ignored; no effect on the frame in flight.
//  - start in the same cycle as done (state IDLE): accepted; cs is high for exactly 1 cycle.
//  - data_in changes after the accept cycle: no effect on the current frame.
// CONFIGURATION
//  SPI_TX_HOLD_EN defined: adds a one-entry holding register.
//   - ready = !hold_valid. A start while busy loads the hold register.
//   - On reaching IDLE with hold_valid=1, the held word starts automatically in that
//     same cycle: done pulses, cs is high for 1 cycle, then the next LEAD.
//   - Reset clears hold_valid.
//  Not defined: no hold register; ready = !busy; start while busy is dropped.
// TESTING (BITS=32, CLKDIV=4; reference model = spi_slave_in on the same clk)
//  1. start with data_in=0xA5A51234 -> cs low 264 cycles, 32 sck rises;
//     slave out_buf=0xA5A51234; done one cycle.
//  2. data_in=0x80000001 -> mosi=0 at the 1st falling edge, 1 at the 2nd..31st, 0 at the 32nd.
//  3. Macro off: second start (data 0x0) 10 cycles after the first -> ignored,
//     one done, out_buf = first word.
//  4. reset_n=0 for 1 cycle after 10 falling edges -> next cycle cs=1, sck=0, mosi=0,
//     busy=0; new start with 0xFFFFFFFF -> out_buf=0xFFFFFFFF.
//  5. start asserted in the done cycle with 0x12345678 -> cs high exactly 1 cycle,
//     out_buf=0x12345678.
//  6. SPI_TX_HOLD_EN: start 0x11111111, then 0x22222222 while busy -> ready=0 until
//     the 2nd frame starts; two done pulses 265 cycles apart; final out_buf=0x22222222.

Source files
------------

// File: rtl/spi_master_out.sv
// ---------------------------------------------------------------------------
// spi_master_out
//   Output-only SPI master feeding the spi_slave_in receiver. A BITS-wide word
//   goes out MSB first on cs/sck/mosi. mosi carries the inverted data bit,
//   because the receiver shifts in !mosi on each falling SCK edge.
//
//   Frame: IDLE -> LEAD -> (HIGH -> LOW) x BITS -> TAIL -> IDLE. Each of LEAD,
//   HIGH, LOW and TAIL lasts CLKDIV clk cycles, so cs is low for
//   CLKDIV*(2*BITS+2) cycles. Every output is registered.
//
// Parameters
//   BITS     word length in bits (>= 2)
//   CLKDIV   clk cycles per SCK half-period (>= 3)
//
// Ports
//   clk      system clock, posedge
//   reset_n  synchronous reset, active low
//   start    transfer request, taken when ready=1
//   data_in  word to send, sampled in the accept cycle
//   ready    start will be accepted this cycle
//   busy     frame in progress
//   done     one-cycle pulse as cs returns high
//   cs       chip select, active low
//   sck      serial clock, idle low
//   mosi     inverted data bit, MSB first
//
// Build option
//   SPI_TX_HOLD_EN  adds a one-entry holding register. ready = !hold_valid.
//                   A start while busy is parked in the register and goes out
//                   one cycle after the current frame's done.
// ---------------------------------------------------------------------------
module spi_master_out #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned CLKDIV = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [BITS-1:0] data_in,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            cs,
  output logic            sck,
  output logic            mosi
);

  localparam int unsigned CW = $clog2(BITS);
  localparam int unsigned DW = $clog2(CLKDIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TAIL
  } state_t;

  state_t          state_q;
  logic [BITS-1:0] shreg_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   div_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            cs_q;
  logic            sck_q;
  logic            mosi_q;
  logic            div_last_d;
  logic            cnt_last_d;

`ifdef SPI_TX_HOLD_EN
  logic [BITS-1:0] hold_q;
  logic            hold_valid_q;
`endif

  always_comb begin
    div_last_d = (div_q == DIV_LAST);
    cnt_last_d = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
`ifdef SPI_TX_HOLD_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // The divider runs through every non-idle phase and wraps on the phase boundary.
      if (state_q != S_IDLE) begin
        div_q <= div_last_d ? '0 : div_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
`ifdef SPI_TX_HOLD_EN
          // A parked word takes priority and starts straight from IDLE.
          if (hold_valid_q) begin
            state_q      <= S_LEAD;
            shreg_q      <= hold_q;
            cnt_q        <= '0;
            div_q        <= '0;
            cs_q         <= 1'b0;
            busy_q       <= 1'b1;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end else if (start && ready_q) begin
            state_q <= S_LEAD;
            shreg_q <= data_in;
            cnt_q   <= '0;
            div_q   <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
`else
          if (start && ready_q) begin
            state_q <= S_LEAD;
            shreg_q <= data_in;
            cnt_q   <= '0;
            div_q   <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
`endif
        end

        S_LEAD: begin
          if (div_last_d) begin
            state_q <= S_HIGH;
            sck_q   <= 1'b1;
            mosi_q  <= ~shreg_q[BITS-1];
          end
        end

        S_HIGH: begin
          if (div_last_d) begin
            state_q <= S_LOW;
            sck_q   <= 1'b0;
          end
        end

        S_LOW: begin
          if (div_last_d) begin
            if (cnt_last_d) begin
              state_q <= S_TAIL;
            end else begin
              // mosi is taken from the bit that becomes the MSB after this shift.
              state_q <= S_HIGH;
              shreg_q <= {shreg_q[BITS-2:0], 1'b0};
              cnt_q   <= cnt_q + 1'b1;
              sck_q   <= 1'b1;
              mosi_q  <= ~shreg_q[BITS-2];
            end
          end
        end

        S_TAIL: begin
          if (div_last_d) begin
            state_q <= S_IDLE;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifndef SPI_TX_HOLD_EN
            ready_q <= 1'b1;
`endif
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

`ifdef SPI_TX_HOLD_EN
      if (start && ready_q && (state_q != S_IDLE)) begin
        hold_q       <= data_in;
        hold_valid_q <= 1'b1;
        ready_q      <= 1'b0;
      end
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign cs    = cs_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_out.sv
// ---------------------------------------------------------------------------
// tb_spi_master_out
//   Bench for spi_master_out (BITS=32, CLKDIV=4). A receiver model on the
//   negative clk edge counts cs-low cycles and SCK edges. On each falling SCK
//   edge it shifts in !mosi, and it copies the word to out_buf when cs rises.
//   Table vectors cover full frames, and hand sequences cover mid-frame
//   reset, back-to-back start and start-while-busy.
// ---------------------------------------------------------------------------
module tb_spi_master_out;

  localparam int unsigned BITS   = 32;
  localparam int unsigned CLKDIV = 4;
  localparam int unsigned CS_LOW = 264;  // 4*(2*32+2)
  localparam int unsigned LAT    = 265;  // accept edge to done, in cycles

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] data_in;
  logic        ready, busy, done, cs, sck, mosi;

  spi_master_out #(.BITS(BITS), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .ready(ready), .busy(busy), .done(done), .cs(cs), .sck(sck), .mosi(mosi)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0;
  int unsigned cyc = 0, acc_cyc = 0, done_cyc = 0;
  int unsigned cs_low_cnt = 0, rises = 0, falls = 0, done_cnt = 0, mosi_glitch = 0;
  int unsigned cs_hi_cnt = 0, cs_hi_run = 0;
  logic [31:0] rx = '0, out_buf = '0, mosi_vec = '0;
  logic        sck_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;

  // Receiver model and frame statistics.
  always @(negedge clk) begin
    cyc++;
    if (cs === 1'b0) cs_low_cnt++;
    if (cs === 1'b0 && cs_prev === 1'b1) begin
      cs_hi_run = cs_hi_cnt;
      cs_hi_cnt = 0;
    end
    if (cs === 1'b1) cs_hi_cnt++;
    if (sck === 1'b1 && sck_prev === 1'b0) rises++;
    if (sck === 1'b0 && sck_prev === 1'b1 && cs === 1'b0) begin
      falls++;
      rx       = {rx[30:0], ~mosi};
      mosi_vec = {mosi_vec[30:0], mosi};
    end
    if (cs === 1'b0 && mosi !== mosi_prev && !(sck === 1'b1 && sck_prev === 1'b0))
      mosi_glitch++;
    if (cs === 1'b1 && cs_prev === 1'b0) out_buf = rx;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    sck_prev  = sck;
    cs_prev   = cs;
    mosi_prev = mosi;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cs_low_cnt  = 0;
    rises       = 0;
    falls       = 0;
    done_cnt    = 0;
    mosi_glitch = 0;
    mosi_vec    = '0;
  endtask

  task automatic send(input logic [31:0] w);
    int unsigned n = 0;
    bit rdy = 1'b0;
    while (!rdy && n < 1000) begin
      @(negedge clk); #1;
      n++;
      rdy = (ready === 1'b1);
    end
    chk("send_ready", rdy, 1);
    start   = 1'b1;
    data_in = w;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start   = 1'b0;
    data_in = $urandom;
  endtask

  task automatic wait_done(input int unsigned maxc, output bit seen);
    int unsigned n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge clk); #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_buf;
    logic [31:0] exp_mosi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit seen;
    int unsigned first_done;
    int unsigned n;

    vecs[0] = '{32'hA5A51234, 32'hA5A51234, 32'h5A5AEDCB};
    vecs[1] = '{32'h80000001, 32'h80000001, 32'h7FFFFFFE};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    reset_n = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full frames from the table.
    foreach (vecs[i]) begin
      clear_mon();
      send(vecs[i].data);
      wait_done(400, seen);
      chk("done_seen", seen, 1);
      chk("latency", done_cyc - acc_cyc, LAT);
      chk("out_buf", out_buf, vecs[i].exp_buf);
      chk("mosi_at_falls", mosi_vec, vecs[i].exp_mosi);
      chk("cs_low_cycles", cs_low_cnt, CS_LOW);
      chk("sck_rises", rises, 32);
      chk("sck_falls", falls, 32);
      chk("mosi_stable", mosi_glitch, 0);
      chk("cs_after", cs, 1);
      repeat (3) @(negedge clk);
      #1;
      chk("done_once", done_cnt, 1);
      chk("busy_after", busy, 0);
    end

`ifndef SPI_TX_HOLD_EN
    // A start while busy is dropped.
    clear_mon();
    send(32'hA5A51234);
    repeat (10) @(negedge clk);
    #1;
    chk("busy_mid", busy, 1);
    chk("ready_mid", ready, 0);
    start   = 1'b1;
    data_in = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400, seen);
    chk("ign_done_seen", seen, 1);
    chk("ign_out_buf", out_buf, 32'hA5A51234);
    repeat (300) @(negedge clk);
    #1;
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_cs_low", cs_low_cnt, CS_LOW);
    chk("ign_busy", busy, 0);
`else
    // A start while busy is parked and sent right after the current frame.
    clear_mon();
    send(32'h11111111);
    repeat (10) @(negedge clk);
    #1;
    chk("hold_ready_empty", ready, 1);
    start   = 1'b1;
    data_in = 32'h22222222;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = $urandom;
    @(negedge clk); #1;
    chk("hold_ready_full", ready, 0);
    wait_done(400, seen);
    chk("hold_done1", seen, 1);
    first_done = done_cyc;
    chk("hold_lat1", done_cyc - acc_cyc, LAT);
    chk("hold_buf1", out_buf, 32'h11111111);
    chk("hold_ready_at_done", ready, 0);
    wait_done(400, seen);
    chk("hold_done2", seen, 1);
    chk("hold_gap", done_cyc - first_done, 265);
    chk("hold_buf2", out_buf, 32'h22222222);
    chk("hold_cs_high", cs_hi_run, 1);
    chk("hold_ready_end", ready, 1);
    chk("hold_done_cnt", done_cnt, 2);
`endif

    // Reset mid-frame after 10 falling edges, then a clean frame.
    clear_mon();
    send(32'hA5A51234);
    n = 0;
    while (falls < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_falls_reached", falls, 10);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_cs", cs, 1);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_mosi", mosi, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    clear_mon();
    send(32'hFFFFFFFF);
    wait_done(400, seen);
    chk("mid_done_seen", seen, 1);
    chk("mid_out_buf", out_buf, 32'hFFFFFFFF);
    chk("mid_cs_low", cs_low_cnt, CS_LOW);

    // Start in the done cycle: cs goes high for exactly one cycle.
    clear_mon();
    send(32'h0F0F0F0F);
    wait_done(400, seen);
    chk("b2b_done1", seen, 1);
    chk("b2b_buf1", out_buf, 32'h0F0F0F0F);
    chk("b2b_ready", ready, 1);
    start   = 1'b1;
    data_in = 32'h12345678;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start   = 1'b0;
    data_in = $urandom;
    wait_done(400, seen);
    chk("b2b_done2", seen, 1);
    chk("b2b_lat", done_cyc - acc_cyc, LAT);
    chk("b2b_cs_high", cs_hi_run, 1);
    chk("b2b_buf2", out_buf, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
